// File: rtl/alu_unit_pkg.sv
// Shared ALU constants: default width, opcode encodings and flag bundle.
// Imported by every file of the ALU slice.
package alu_unit_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_OP_W  = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sub=1 computes a-b as a+~b+1.
// carry is the raw carry-out, so for subtract it means "no borrow".
module alu_addsub
  import alu_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  always_comb begin
    bx   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bx}
         + {{WIDTH{1'b0}}, sub};
  end

  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

  // Same-sign operands (after inversion) whose result flips sign.
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// Registered ALU: logic ops, shifter and result/flag registers.
// Result and flags appear one EN edge after operands are sampled.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                EN,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [ALU_OP_W-1:0] ALUop,
  output logic [WIDTH-1:0]    Output,
  output logic                zero,
  output logic                negative,
  output logic                carry,
  output logic                overflow
);

  alu_op_e          op;
  logic [3:0]       sh;
  logic [WIDTH-1:0] as_sum;
  logic             as_c;
  logic             as_v;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [WIDTH:0]   sra;

  logic [WIDTH-1:0] res_d, res_q;
  alu_flags_t       flg_d, flg_q;
  logic             c_d, v_d, valid;

  assign op = alu_op_e'(ALUop);
  assign sh = B[3:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (A),
    .b        (B),
    .sub      (op == ALU_SUB),
    .sum      (as_sum),
    .carry    (as_c),
    .overflow (as_v)
  );

  // Extra guard bit catches the last bit shifted out.
  always_comb begin
    shl = {1'b0, A} << sh;
    shr = {A, 1'b0} >> sh;
    sra = $signed({A, 1'b0}) >>> sh;
  end

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    valid = 1'b1;
    case (op)
      ALU_AND:   res_d = A & B;
      ALU_OR:    res_d = A | B;
      ALU_XOR:   res_d = A ^ B;
      ALU_NOT:   res_d = ~A;
      ALU_PASSB: res_d = B;
      ALU_ADD, ALU_SUB: begin
        res_d = as_sum;
        c_d   = as_c;
        v_d   = as_v;
      end
      ALU_SLL: begin
        res_d = shl[WIDTH-1:0];
        c_d   = shl[WIDTH];
      end
      ALU_SRL: begin
        res_d = shr[WIDTH:1];
        c_d   = shr[0];
      end
      ALU_SRA: begin
        res_d = sra[WIDTH:1];
        c_d   = sra[0];
      end
      default: valid = 1'b0;
    endcase
    flg_d.zero     = valid && (res_d == '0);
    flg_d.negative = valid && res_d[WIDTH-1];
    flg_d.carry    = c_d;
    flg_d.overflow = v_d;
  end

  always_ff @(posedge EN or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      flg_q <= '0;
    end else begin
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign Output   = res_q;
  assign zero     = flg_q.zero;
  assign negative = flg_q.negative;
  assign carry    = flg_q.carry;
  assign overflow = flg_q.overflow;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases, reset, and
// random ops against an arithmetic reference model.
module tb_alu_unit;

  logic        EN;
  logic        reset_n;
  logic [15:0] A, B;
  logic [3:0]  ALUop;
  logic [15:0] Output;
  logic        zero, negative, carry, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  alu_unit #(.WIDTH(16)) dut (
    .EN       (EN),
    .reset_n  (reset_n),
    .A        (A),
    .B        (B),
    .ALUop    (ALUop),
    .Output   (Output),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  initial EN = 1'b0;
  always #5 EN = ~EN;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input  logic [15:0] a,
                       input  logic [15:0] b,
                       input  logic [3:0]  op,
                       output logic [15:0] r,
                       output logic z, n, c, v);
    int ua, ub, sa, sb, t, s;
    bit ok;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[3:0]);
    t  = 0;
    c  = 1'b0;
    v  = 1'b0;
    ok = 1'b1;
    case (op)
      4'd0: t = ua & ub;
      4'd1: begin
        t = ua + ub;
        c = (t > 65535);
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd2: begin
        t = ua - ub;
        c = (ua >= ub);
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd3: t = ua | ub;
      4'd4: t = ua ^ ub;
      4'd5: t = ~ua;
      4'd6: begin
        t = ua << s;
        c = (s != 0) && (((ua >> (16 - s)) & 1) == 1);
      end
      4'd7: begin
        t = ua >> s;
        c = (s != 0) && (((ua >> (s - 1)) & 1) == 1);
      end
      4'd8: begin
        t = sa >>> s;
        c = (s != 0) && (((sa >>> (s - 1)) & 1) == 1);
      end
      4'd9: t = ub;
      default: ok = 1'b0;
    endcase
    r = ok ? t[15:0] : 16'h0;
    z = ok && (r == 16'h0);
    n = ok && r[15];
  endtask

  task automatic apply(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0]  op);
    @(negedge EN);
    A = a;
    B = b;
    ALUop = op;
    @(posedge EN);
    #1;
  endtask

  task automatic check_model(input string tag,
                             input logic [15:0] a,
                             input logic [15:0] b,
                             input logic [3:0]  op);
    logic [15:0] r;
    logic z, n, c, v;
    model(a, b, op, r, z, n, c, v);
    check_eq({tag, ".out"}, 32'(Output), 32'(r));
    check_eq({tag, ".z"}, 32'(zero), 32'(z));
    check_eq({tag, ".n"}, 32'(negative), 32'(n));
    check_eq({tag, ".c"}, 32'(carry), 32'(c));
    check_eq({tag, ".v"}, 32'(overflow), 32'(v));
  endtask

  task automatic directed(input string tag,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [3:0]  op,
                          input logic [15:0] exp_out);
    apply(a, b, op);
    check_eq({tag, ".const"}, 32'(Output), 32'(exp_out));
    check_model(tag, a, b, op);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, ".out"}, 32'(Output), 32'h0);
    check_eq({tag, ".flags"},
             32'({zero, negative, carry, overflow}), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    A = 16'h0;
    B = 16'h0;
    ALUop = 4'd0;
    #2;
    check_cleared("rst_init");
    @(negedge EN);
    check_cleared("rst_hold");
    reset_n = 1'b1;

    directed("and",     16'd15,   16'd30,  4'd0, 16'd14);
    check_eq("and.zlit", 32'(zero), 32'h0);
    directed("add",     16'd16,   16'd101, 4'd1, 16'd117);
    directed("sub_pos", 16'd44,   16'd15,  4'd2, 16'd29);
    check_eq("sub_pos.clit", 32'(carry), 32'h1);
    directed("sub_neg", 16'd15,   16'd44,  4'd2, 16'hFFE3);
    check_eq("sub_neg.nlit", 32'(negative), 32'h1);
    directed("add_ovf", 16'h7FFF, 16'd1,   4'd1, 16'h8000);
    check_eq("add_ovf.vlit", 32'(overflow), 32'h1);
    directed("add_wrap", 16'hFFFF, 16'd1,  4'd1, 16'h0000);
    check_eq("add_wrap.clit", 32'(carry), 32'h1);
    check_eq("add_wrap.zlit", 32'(zero), 32'h1);
    directed("sra",     16'h8001, 16'd1,   4'd8, 16'hC000);
    check_eq("sra.clit", 32'(carry), 32'h1);
    directed("sll0",    16'h8001, 16'h0,   4'd6, 16'h8001);
    directed("sll15",   16'h0003, 16'hFF0F, 4'd6, 16'h8000);
    directed("srl15",   16'h8000, 16'd15,  4'd7, 16'h0001);
    directed("sub_eq",  16'h1234, 16'h1234, 4'd2, 16'h0000);
    directed("sub_ovf", 16'h8000, 16'd1,   4'd2, 16'h7FFF);
    directed("bad_op",  16'hFFFF, 16'h0001, 4'd12, 16'h0000);

    // Reset asserted mid-period with an ADD result on the outputs.
    directed("pre_rst", 16'h7FFF, 16'd1, 4'd1, 16'h8000);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("rst_async");
    A = 16'h00FF;
    B = 16'h00FF;
    ALUop = 4'd4;
    A = 16'hFFFF;
    ALUop = 4'd1;
    repeat (2) @(posedge EN);
    #1;
    check_cleared("rst_held");
    @(negedge EN);
    reset_n = 1'b1;
    directed("post_rst", 16'h00F0, 16'h0F0F, 4'd3, 16'h0FFF);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      if (i % 8 == 0) ra = 16'h8000;
      apply(ra, rb, rop);
      check_model($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width; all widths below assume 16.
REQ-002 SHALL have port EN  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port A  input  16  first operand.
REQ-005 SHALL have port B  input  16  second operand; shift amount in shift ops.
REQ-006 SHALL have port ALUop  input  4  operation select.
REQ-007 SHALL have port Output  output  16  registered result.
REQ-008 SHALL have ports zero, negative, carry, overflow  output  1 each  registered status flags.

Function
REQ-009 SHALL sample A, B and ALUop on each rising EN edge; Output and flags update on that edge (latency 1 cycle, no stall or handshake).
REQ-010 SHALL decode ALUop as: 0 AND, 1 ADD, 2 SUB, 3 OR, 4 XOR, 5 NOT (~A), 6 SLL, 7 SRL, 8 SRA, 9 PASSB (B).
REQ-011 SHALL load Output = 0 and clear all flags for codes 10-15.
REQ-012 SHALL compute ADD as A+B modulo 2^16; carry = bit 16 of the 17-bit sum.
REQ-013 SHALL compute SUB as A-B modulo 2^16; carry = 1 when A >= B unsigned (no borrow).
REQ-014 SHALL set overflow for ADD when A[15]==B[15] and result[15]!=A[15].
REQ-015 SHALL set overflow for SUB when A[15]!=B[15] and result[15]!=A[15].
REQ-016 SHALL use B[3:0] as shift amount for SLL/SRL/SRA; B[15:4] ignored.
REQ-017 SHALL fill SLL/SRL with zeros and SRA with A[15].
REQ-018 SHALL set carry for shifts to the last bit shifted out, 0 when amount is 0.
REQ-019 SHALL clear carry and overflow for AND, OR, XOR, NOT and PASSB.
REQ-020 SHALL set zero = (result == 0) and negative = result[15] for every valid code.
REQ-021 SHALL let a change of ALUop between edges affect only the next registered result; no combinational path from inputs to outputs.

Reset
REQ-022 SHALL drive Output = 0 and all flags = 0 immediately when reset_n falls, independent of EN.
REQ-023 SHALL hold these values while reset_n is low.
REQ-024 SHALL capture operands on the first rising EN edge after reset_n rises.
REQ-025 SHALL, when reset is asserted mid-operation, discard the in-flight result and never present it.

Structure
REQ-026 SHALL take the opcode constants (ALU_AND, ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_NOT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB) and WIDTH default from the shared constants file; no numeric opcode literals in RTL.
REQ-027 SHALL place adder/subtractor with carry/overflow in one sub-module alu_addsub.
REQ-028 SHALL implement the remaining logic, shifter and output/flag registers in alu_unit.
REQ-029 SHALL leave ClockGenerator outside the DUT; it is bench infrastructure that produces EN.

Verification
REQ-030 SHALL check: A=15, B=30, AND -> Output=14 after one edge, zero=0, negative=0, carry=0.
REQ-031 SHALL check: A=16, B=101, ADD -> Output=117, carry=0, overflow=0.
REQ-032 SHALL check: A=44, B=15, SUB -> Output=29, carry=1.
REQ-033 SHALL check: A=15, B=44, SUB -> Output=0xFFE3, negative=1, carry=0.
REQ-034 SHALL check: A=0x7FFF, B=1, ADD -> Output=0x8000, overflow=1, negative=1.
REQ-035 SHALL check: A=0xFFFF, B=1, ADD -> Output=0, zero=1, carry=1.
REQ-036 SHALL check: A=0x8001, B=1, SRA -> Output=0xC000, carry=1.
REQ-037 SHALL check: reset_n low mid-clock-period after an ADD -> Output=0 and flags=0 before the next EN edge, held until release.
